// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 serial receiver on clk_sis with a valid/ack byte handshake.
// The bit timing comes from a CLKS_PER_BIT divider; all decisions use the synchronised rx_s.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk_sis,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx_s;
    logic [1:0]           primed;
    logic                 armed;
    logic [CW-1:0]        clk_cnt, clk_cnt_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 load_req, ferr_req, load_q;

    // Two-flop synchroniser; armed is set only once rx_s is known to reflect the
    // real line (primed) and is high, so a line held low through reset is not
    // mistaken for a start edge.
    always_ff @(posedge clk_sis or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            primed  <= '0;
            armed   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            primed  <= {primed[0], 1'b1};
            if (primed[1] && rx_s)
                armed <= 1'b1;
        end
    end

    // FSM state, bit-timing counters and the receive shift register.
    always_ff @(posedge clk_sis or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
        end
    end

    // Next-state logic: mid-bit sampling of start, data and stop bits.
    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt + CW'(1);
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        load_req  = 1'b0;
        ferr_req  = 1'b0;
        case (state)
            S_IDLE: begin
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                if (armed && !rx_s)
                    state_n = S_START;
            end
            S_START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_n = '0;
                    state_n   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_n = '0;
                    shift_n   = {rx_s, shift[DATA_BITS-1:1]};
                    bit_cnt_n = bit_cnt + BW'(1);
                    if (bit_cnt == LAST_BIT)
                        state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_n = '0;
                    if (rx_s) begin
                        load_req = 1'b1;
                        state_n  = S_IDLE;
                    end else begin
                        ferr_req = 1'b1;
                        state_n  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                clk_cnt_n = '0;
                if (rx_s)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Output register: load a good byte one cycle after mid-stop, handle ack/overrun.
    always_ff @(posedge clk_sis or negedge rst) begin
        if (!rst) begin
            load_q      <= 1'b0;
            frame_err   <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            load_q    <= load_req;
            frame_err <= ferr_req;
            if (load_q) begin
                data_out   <= shift;
                data_valid <= 1'b1;
                if (rd_ack)
                    overrun_err <= 1'b0;
                else if (data_valid)
                    overrun_err <= 1'b1;
            end else if (rd_ack && data_valid) begin
                data_valid  <= 1'b0;
                overrun_err <= 1'b0;
            end
        end
    end

    // Busy whenever a frame (or a held-low break) is in progress.
    always_comb begin
        busy = (state != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed vector table, hand-written corner sequences and
// randomized frames checked against a byte-level model of the receiver.
module tb_uart_rx_core;

    localparam int CPB = 16;
    localparam int DB  = 8;
    localparam int LAT = 2 + CPB / 2 + (DB + 1) * CPB + 1;

    logic          clk_sis = 1'b0;
    logic          rst     = 1'b0;
    logic          rx      = 1'b1;
    logic          rd_ack  = 1'b0;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          overrun_err;
    logic          busy;

    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk_sis     (clk_sis),
        .rst         (rst),
        .rx          (rx),
        .rd_ack      (rd_ack),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk_sis = ~clk_sis;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rise_cyc = -1;
    int   fe_count = 0;
    logic dv_prev  = 1'b0;

    // Passive monitor: cycle count, data_valid rising edge, frame_err pulse count.
    always begin
        @(posedge clk_sis);
        cyc = cyc + 1;
        #1;
        if (data_valid === 1'b1 && dv_prev !== 1'b1)
            rise_cyc = cyc;
        dv_prev = data_valid;
        if (frame_err === 1'b1)
            fe_count = fe_count + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input bit dv, input bit ovr);
        chk({tag, " data_out"}, data_out, d);
        chk({tag, " data_valid"}, data_valid, dv);
        chk({tag, " overrun_err"}, overrun_err, ovr);
        chk({tag, " busy"}, busy, 0);
    endtask

    // Drives one frame, one bit per CPB cycles; t-th iteration feeds edge start+t.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int ack_at,
                              input int rst_at, input int rst_len, output int start);
        logic [9:0] bits;
        bits  = {stop_ok, d, 1'b0};
        start = cyc + 1;
        for (int t = 0; t < 10 * CPB; t++) begin
            rx     = bits[t / CPB];
            rd_ack = (t == ack_at);
            if (rst_at >= 0 && t == rst_at) begin
                rst = 1'b0;
                #1;
                chk("reset mid-frame data_out", data_out, 0);
                chk("reset mid-frame data_valid", data_valid, 0);
                chk("reset mid-frame frame_err", frame_err, 0);
                chk("reset mid-frame overrun_err", overrun_err, 0);
                chk("reset mid-frame busy", busy, 0);
            end
            if (rst_at >= 0 && t == rst_at + rst_len)
                rst = 1'b1;
            @(negedge clk_sis);
        end
        rx     = 1'b1;
        rd_ack = 1'b0;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk_sis);
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        @(negedge clk_sis);
        rd_ack = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         gap;
        bit         ack;
        logic [7:0] exp_data;
        bit         exp_dv;
        bit         exp_ovr;
        int         exp_fe;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] m_data;
    bit         m_dv, m_ovr, prev_dv;
    int         start, fe0, gap, mode;
    logic [7:0] b;
    bit         stop_ok;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 1'b1, 8'hA5, 1'b1, 1'b0, 0};
        vecs[1] = '{8'h3C, 1'b0, 2, 1'b0, 8'hA5, 1'b0, 1'b0, 1};
        vecs[2] = '{8'h81, 1'b1, 1, 1'b1, 8'h81, 1'b1, 1'b0, 0};
        vecs[3] = '{8'h11, 1'b1, 0, 1'b0, 8'h11, 1'b1, 1'b0, 0};
        vecs[4] = '{8'h22, 1'b1, 1, 1'b1, 8'h22, 1'b1, 1'b1, 0};
        vecs[5] = '{8'hC3, 1'b1, 2, 1'b1, 8'hC3, 1'b1, 1'b0, 0};

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk_sis);
        chk("reset data_out", data_out, 0);
        chk("reset data_valid", data_valid, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset overrun_err", overrun_err, 0);
        chk("reset busy", busy, 0);
        rst = 1'b1;
        idle_bits(1);

        // Directed vector table
        prev_dv = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            fe0      = fe_count;
            rise_cyc = -1;
            send_frame(vecs[i].data, vecs[i].stop_ok, -1, -1, 0, start);
            idle_bits(vecs[i].gap);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_dv, vecs[i].exp_ovr);
            chk($sformatf("vec%0d frame_err pulses", i), fe_count - fe0, vecs[i].exp_fe);
            if (vecs[i].stop_ok && !prev_dv)
                chk($sformatf("vec%0d latency", i), rise_cyc - start, LAT);
            prev_dv = vecs[i].exp_dv;
            if (vecs[i].ack) begin
                ack_pulse();
                chk($sformatf("vec%0d ack data_valid", i), data_valid, 0);
                chk($sformatf("vec%0d ack overrun_err", i), overrun_err, 0);
                prev_dv = 1'b0;
            end
        end

        // Glitch: short low pulse returns to IDLE without flags
        fe0 = fe_count;
        rx  = 1'b0;
        repeat (5) @(negedge clk_sis);
        chk("glitch busy during", busy, 1);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk_sis);
        chk_out("glitch", 8'hC3, 1'b0, 1'b0);
        chk("glitch frame_err pulses", fe_count - fe0, 0);

        // rd_ack in the exact completion cycle while a byte is pending
        send_frame(8'h44, 1'b1, -1, -1, 0, start);
        idle_bits(1);
        chk_out("pending 44", 8'h44, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, LAT, -1, 0, start);
        idle_bits(1);
        chk_out("ack-at-load 55", 8'h55, 1'b1, 1'b0);
        ack_pulse();
        chk("ack-at-load cleared", data_valid, 0);

        // Reset during data bit 4 with a pending overrun
        send_frame(8'h01, 1'b1, -1, -1, 0, start);
        send_frame(8'h02, 1'b1, -1, -1, 0, start);
        idle_bits(1);
        chk_out("pre-reset overrun", 8'h02, 1'b1, 1'b1);
        fe0 = fe_count;
        send_frame(8'hF0, 1'b1, -1, 5 * CPB + 4, 3, start);
        idle_bits(1);
        chk_out("post-reset idle", 8'h00, 1'b0, 1'b0);
        chk("post-reset frame_err pulses", fe_count - fe0, 0);
        rise_cyc = -1;
        send_frame(8'h0F, 1'b1, -1, -1, 0, start);
        idle_bits(1);
        chk_out("post-reset 0F", 8'h0F, 1'b1, 1'b0);
        chk("post-reset 0F latency", rise_cyc - start, LAT);
        ack_pulse();

        // Line held low across reset release must not start a frame
        rx  = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk_sis);
        rst = 1'b1;
        repeat (3 * CPB) @(negedge clk_sis);
        chk("held-low busy", busy, 0);
        chk("held-low data_valid", data_valid, 0);
        idle_bits(1);
        rise_cyc = -1;
        send_frame(8'h5A, 1'b1, -1, -1, 0, start);
        idle_bits(1);
        chk_out("after held-low 5A", 8'h5A, 1'b1, 1'b0);
        chk("after held-low latency", rise_cyc - start, LAT);
        ack_pulse();

        // Randomized frames against a byte-level model
        m_data = 8'h5A;
        m_dv   = 1'b0;
        m_ovr  = 1'b0;
        for (int unsigned n = 0; n < 30; n++) begin
            b       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 7) != 0);
            mode    = int'($urandom_range(0, 2));
            if (!stop_ok && mode == 2)
                mode = 1;
            gap      = stop_ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            prev_dv  = m_dv;
            fe0      = fe_count;
            rise_cyc = -1;
            send_frame(b, stop_ok, (mode == 2) ? LAT : -1, -1, 0, start);
            if (stop_ok) begin
                m_ovr  = (mode == 2) ? 1'b0 : (m_ovr | m_dv);
                m_dv   = 1'b1;
                m_data = b;
            end
            idle_bits(gap);
            chk_out($sformatf("rand%0d", n), m_data, m_dv, m_ovr);
            chk($sformatf("rand%0d frame_err pulses", n), fe_count - fe0, stop_ok ? 0 : 1);
            if (stop_ok && !prev_dv)
                chk($sformatf("rand%0d latency", n), rise_cyc - start, LAT);
            if (mode == 1) begin
                ack_pulse();
                if (m_dv) begin
                    m_dv  = 1'b0;
                    m_ovr = 1'b0;
                end
                chk($sformatf("rand%0d ack data_valid", n), data_valid, m_dv);
                chk($sformatf("rand%0d ack overrun_err", n), overrun_err, m_ovr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
